// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } dmem_req_t;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage with byte-enabled synchronous write and registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     we,
  input  logic                     rd_en,
  input  logic [BE_W-1:0]          be,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] data_memory [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately not reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (reset && en && we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be[b]) begin
          data_memory[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Writes and suppressed reads return zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= '0;
    end else if (en) begin
      rdata_q <= rd_en ? data_memory[idx] : '0;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding request/response data memory with configurable wait states.
// Optional misalignment checking is compiled in with DMEM_MISALIGN_ERR_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WaitLoad =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             live_q;
  dmem_req_t        hold_q;
  dmem_req_t        live_req;
  dmem_req_t        acc_req;
  logic             accept;
  logic             access;
  logic             misalign;

  assign live_req = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
  assign accept   = req_valid && req_ready;

  // State register; live_q keeps req_ready low until the first edge out of reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WaitLoad;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE) && live_q;
    rsp_valid = (state_q == RESP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (accept) begin
      hold_q <= live_req;
    end
  end

  // With zero wait states the access happens on the handshake edge, before hold_q loads.
  assign acc_req = (state_q == IDLE) ? live_req : hold_q;
  assign access  = reset && (state_d == RESP) && (state_q != RESP);

`ifdef DMEM_MISALIGN_ERR_EN
  logic err_q;

  assign misalign = is_misaligned(acc_req.addr);

  always_ff @(posedge clk) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (access) begin
      err_q <= misalign;
    end
  end

  assign rsp_err = err_q;

  logic unused_addr;
  assign unused_addr = ^acc_req.addr[ADDR_W-1:IdxW+2];
`else
  assign misalign = 1'b0;
  assign rsp_err  = 1'b0;

  logic unused_addr;
  assign unused_addr = ^{acc_req.addr[ADDR_W-1:IdxW+2], acc_req.addr[1:0]};
`endif

  dmem_array #(
    .DEPTH(DEPTH)
  ) D0 (
    .clk  (clk),
    .reset(reset),
    .en   (access),
    .we   (acc_req.we && !misalign),
    .rd_en(!acc_req.we && !misalign),
    .be   (acc_req.be),
    .idx  (acc_req.addr[IdxW+1:2]),
    .wdata(acc_req.wdata),
    .rdata(rsp_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with two wait states, one with none.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [31:0] z_req_addr, z_req_wdata;
  logic [3:0]  z_req_be;
  logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err)
  );

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, output logic ok);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready) ok = 1'b1;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // lat = edges from the handshake edge to the first edge that samples rsp_valid high.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    dut.D0.data_memory[0] <= 32'd5;
    dut.D0.data_memory[1] <= 32'd10;
    dut.D0.data_memory[2] <= 32'd20;
    dut.D0.data_memory[3] <= 32'h33;
    dut0.D0.data_memory[0] <= 32'd5;
    dut0.D0.data_memory[1] <= 32'd10;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL rst_rsp_rdata: got %h want 0", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rst_rsp_err: got %b want 0", rsp_err); end
    reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read_latency();
    logic ok; int lat;
    send(1'b0, 32'h8, 32'h0, 4'hf, ok);
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL rdlat_accept: got %b want 1", ok); end
    wait_rsp(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL rdlat_cycles: got %0d want 3", lat); end
    total++; if (rsp_rdata !== 32'h14) begin bad++; $display("FAIL rdlat_rdata: got %h want 00000014", rsp_rdata); end
    total++; if (rsp_err !== 1'b0) begin bad++; $display("FAIL rdlat_err: got %b want 0", rsp_err); end
    take_rsp();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rdlat_done_valid: got %b want 0", rsp_valid); end
  endtask

  task automatic test_byte_write();
    logic ok; int lat;
    send(1'b1, 32'h8, 32'hAABBCCDD, 4'b0011, ok);
    wait_rsp(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL bwr_cycles: got %0d want 3", lat); end
    total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL bwr_rsp_rdata: got %h want 0", rsp_rdata); end
    take_rsp();
    total++; if (dut.D0.data_memory[2] !== 32'h0000CCDD) begin
      bad++; $display("FAIL bwr_mem: got %h want 0000ccdd", dut.D0.data_memory[2]);
    end
    send(1'b0, 32'h8, 32'h0, 4'hf, ok);
    wait_rsp(lat);
    total++; if (rsp_rdata !== 32'h0000CCDD) begin bad++; $display("FAIL bwr_readback: got %h want 0000ccdd", rsp_rdata); end
    take_rsp();
    send(1'b1, 32'hC, 32'h12345678, 4'b0000, ok);
    wait_rsp(lat);
    total++; if (lat != 3) begin bad++; $display("FAIL be0_cycles: got %0d want 3", lat); end
    take_rsp();
    total++; if (dut.D0.data_memory[3] !== 32'h33) begin
      bad++; $display("FAIL be0_mem: got %h want 00000033", dut.D0.data_memory[3]);
    end
  endtask

  task automatic test_backpressure();
    logic ok; int lat;
    send(1'b0, 32'h4, 32'h0, 4'hf, ok);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA || req_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b want 1 0000000a 0",
                 i, rsp_valid, rsp_rdata, req_ready);
      end
      @(negedge clk);
    end
    take_rsp();
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: got valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    send(1'b1, 32'h0, 32'hFFFFFFFF, 4'hf, ok);
    reset = 1'b0;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_in_reset: got valid=%b ready=%b want 0 0", rsp_valid, req_ready);
    end
    reset = 1'b1;
    @(negedge clk);
    total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_release: got ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    repeat (4) @(negedge clk);
    total++; if (dut.D0.data_memory[0] !== 32'd5) begin
      bad++; $display("FAIL rmid_mem: got %h want 00000005", dut.D0.data_memory[0]);
    end
  endtask

  task automatic test_wrap_misalign();
    logic ok; int lat;
    logic [31:0] exp_rd; logic exp_err;
    send(1'b0, 32'h100, 32'h0, 4'hf, ok);
    wait_rsp(lat);
    total++; if (rsp_rdata !== 32'd5) begin bad++; $display("FAIL wrap_rdata: got %h want 00000005", rsp_rdata); end
    take_rsp();
`ifdef DMEM_MISALIGN_ERR_EN
    exp_rd = 32'h0; exp_err = 1'b1;
`else
    exp_rd = 32'hA; exp_err = 1'b0;
`endif
    send(1'b0, 32'h6, 32'h0, 4'hf, ok);
    wait_rsp(lat);
    total++; if (rsp_rdata !== exp_rd) begin bad++; $display("FAIL mis_rdata: got %h want %h", rsp_rdata, exp_rd); end
    total++; if (rsp_err !== exp_err) begin bad++; $display("FAIL mis_err: got %b want %b", rsp_err, exp_err); end
    take_rsp();
`ifdef DMEM_MISALIGN_ERR_EN
    send(1'b1, 32'h6, 32'hDEADBEEF, 4'hf, ok);
    wait_rsp(lat);
    total++; if (rsp_err !== 1'b1) begin bad++; $display("FAIL mis_wr_err: got %b want 1", rsp_err); end
    take_rsp();
    total++; if (dut.D0.data_memory[1] !== 32'hA) begin
      bad++; $display("FAIL mis_wr_mem: got %h want 0000000a", dut.D0.data_memory[1]);
    end
`endif
  endtask

  task automatic test_back_to_back();
    z_req_valid = 1'b1; z_req_we = 1'b0; z_req_addr = 32'h0; z_req_be = 4'hf;
    total++; if (z_req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready0: got %b want 1", z_req_ready); end
    @(negedge clk);
    total++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'd5 || z_rsp_err !== 1'b0) begin
      bad++; $display("FAIL b2b_first: got valid=%b rdata=%h err=%b want 1 00000005 0",
                      z_rsp_valid, z_rsp_rdata, z_rsp_err);
    end
    z_req_addr = 32'h4;
    @(negedge clk);
    total++; if (z_rsp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_idle: got valid=%b ready=%b want 0 1", z_rsp_valid, z_req_ready);
    end
    @(negedge clk);
    z_req_valid = 1'b0;
    total++; if (z_rsp_valid !== 1'b1 || z_rsp_rdata !== 32'd10) begin
      bad++; $display("FAIL b2b_second: got valid=%b rdata=%h want 1 0000000a", z_rsp_valid, z_rsp_rdata);
    end
    @(negedge clk);
    total++; if (z_rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got %b want 0", z_rsp_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_read_latency();
    test_byte_write();
    test_backpressure();
    test_reset_mid();
    test_wrap_misalign();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- DEPTH, 64, number of 32-bit words stored; power of two.
- WAIT_CYCLES, 2, wait states between request acceptance and response; range 0..15.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  input  1  single clock, rising edge.
- reset  input  1  reset, synchronous, active-low.
- req_valid  input  1  requester presents a transaction.
- req_ready  output  1  responder accepts the transaction this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address.
- req_wdata  input  32  write data.
- req_be  input  4  byte enables; bit i selects byte i.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  requester takes the response.
- rsp_rdata  output  32  read data; 0 for write responses.
- rsp_err  output  1  error flag; 0 when DMEM_MISALIGN_ERR_EN is undefined.

Function
REQ-003 The state machine SHALL have three states: IDLE, WAIT and RESP.
REQ-004 req_ready SHALL be 1 only in IDLE, so at most one transaction is outstanding.
REQ-005 A handshake on req_valid&&req_ready at edge T SHALL capture we, addr, wdata and be into holding registers.
- If WAIT_CYCLES>0, the state SHALL move to WAIT.
- If WAIT_CYCLES=0, the state SHALL move directly to RESP.
REQ-006 In WAIT, a down-counter loaded with WAIT_CYCLES-1 SHALL decrement each cycle. When it reaches 0, the state SHALL move to RESP.
REQ-007 rsp_valid SHALL first be 1 at edge T+1+WAIT_CYCLES.
REQ-008 The memory access SHALL occur on entry to RESP.
- Word index = addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap.
- Writes update only the enabled bytes.
- Reads register the addressed word onto rsp_rdata.
REQ-009 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_ready=1. The state SHALL then return to IDLE on that edge.
REQ-010 rsp_valid SHALL be 0 in every state other than RESP.
REQ-011 A request with req_be=0 SHALL complete normally and SHALL leave memory unchanged.
REQ-012 req_valid asserted while req_ready=0 SHALL be ignored. The requester holds the request until it is accepted.
REQ-013 The storage array SHALL be an unpacked array named data_memory, writable by hierarchical preload from benches.

Reset
REQ-014 When reset=0 at a rising clk edge, the state SHALL go to IDLE, the counter to 0, and rsp_valid, rsp_rdata and rsp_err to 0.
REQ-015 req_ready SHALL be 0 while reset=0, and 1 from the first edge after reset=1.
REQ-016 Memory contents SHALL NOT be cleared by reset.
REQ-017 Reset during WAIT SHALL drop the transaction, and a pending write SHALL NOT be committed.

Configuration
REQ-018 Macro DMEM_MISALIGN_ERR_EN SHALL compile misalignment checking in or out.
- Defined: a request with addr[1:0]!=0 SHALL complete with rsp_err=1, SHALL perform no write, and SHALL return rsp_rdata=0.
- Undefined: addr[1:0] SHALL be ignored, and rsp_err SHALL be tied to 0.

Structure
REQ-019 Package dmem_pkg SHALL hold the following:
- The state enum (IDLE, WAIT, RESP).
- The constants DATA_W=32 and BE_W=4.
- A request struct {we, addr, wdata, be}.
REQ-020 Storage SHALL live in sub-module dmem_array, instance D0, containing data_memory.
- It SHALL provide a synchronous byte-enabled write and a registered read.
- The FSM SHALL stay in data_mem_responder.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Read latency: preload data_memory[2]=20; read at addr 0x8 with WAIT_CYCLES=2 -> rsp_valid 3 cycles after the handshake, rsp_rdata=0x00000014, rsp_err=0.
- Byte-enabled write: data_memory[2]=0x00000014; write 0xAABBCCDD to 0x8 with be=4'b0011 -> data_memory[2]=0x0000CCDD; read-back returns 0x0000CCDD.
- Backpressure: hold rsp_ready=0 for 5 cycles during a read of word 1 (=10) -> rsp_valid=1 and rsp_rdata=0x0000000A stable throughout, req_ready=0; returns to IDLE one edge after rsp_ready=1.
- Reset mid-operation: assert reset=0 in WAIT of a write of 0xFFFFFFFF to 0x0 (word 0=5) -> data_memory[0]=5, rsp_valid=0, req_ready=1 one edge after release.
- Wrap and misalignment:
  - Read 0x100 with DEPTH=64 -> returns data_memory[0].
  - Read 0x6 with the macro defined -> rsp_err=1 and no write.
  - Read 0x6 without the macro -> returns data_memory[1].
- Zero wait: WAIT_CYCLES=0, back-to-back reads of 0x0 and 0x4 with rsp_ready=1 -> rsp_valid at T+1 each, rdata 5 then 10, one transaction per 2 cycles.
